// File: rtl/chimp_game_fsm_pkg.sv
// Shared types and constants for the chimp memory game control path.
package chimp_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    PLACE     = 3'd2,
    SHOW      = 3'd3,
    PLAY      = 3'd4,
    ROUND_WIN = 3'd5,
    STRIKE    = 3'd6,
    GAME_OVER = 3'd7
  } state_t;

  localparam int ACTIVE_BIT = 6;
  localparam int SHOW_BIT   = 5;
  localparam int NUM_MSB    = 4;
  localparam int CELL_W     = 7;
  localparam int NUM_CELLS  = 9;

  // Bit offset of a cell inside the packed board.
  function automatic int cell_lsb(input logic [3:0] idx);
    return CELL_W * int'(idx);
  endfunction

endpackage

// File: rtl/chimp_game_fsm_if.sv
// Game-side bundle: menu/mode/PRNG/click inputs and board/score/status outputs.
interface chimp_game_fsm_if;
  import chimp_pkg::*;

  logic                          iKey0;
  logic [1:0]                    iGameMode;
  logic [7:0]                    iRandNum;
  logic                          iClick;
  logic [2:0]                    iBoxX;
  logic [2:0]                    iBoxY;
  logic [CELL_W*NUM_CELLS-1:0]   oBoard;
  logic [4:0]                    oScore;
  logic [1:0]                    oStrikes;
  logic                          oGameOver;
  logic [2:0]                    oState;

  modport master (
    output iKey0, iGameMode, iRandNum, iClick, iBoxX, iBoxY,
    input  oBoard, oScore, oStrikes, oGameOver, oState
  );

  modport slave (
    input  iKey0, iGameMode, iRandNum, iClick, iBoxX, iBoxY,
    output oBoard, oScore, oStrikes, oGameOver, oState
  );
endinterface

// File: rtl/chimp_free_cell_finder.sv
// Lowest-index inactive cell, used when random placement keeps missing.
module chimp_free_cell_finder
  import chimp_pkg::*;
(
  input  logic [NUM_CELLS-1:0] active_i,
  output logic [3:0]           free_idx_o,
  output logic                 any_free_o
);

  // Scan from the top down so the lowest free index wins.
  always_comb begin
    free_idx_o = '0;
    any_free_o = 1'b0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (!active_i[i]) begin
        free_idx_o = 4'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chimp_game_fsm.sv
// Chimp memory game sequencer: clears, places, shows and scores the 3x3 board.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for game mode 2'b10, then new game
// CLEAR     | wipe board, restart numbering at 1
// PLACE     | one placement attempt per cycle
// SHOW      | numbers visible until the first valid click
// PLAY      | numbers hidden, clicks must follow 1..count
// ROUND_WIN | bump score and count, next round
// STRIKE    | bump strikes, replay or end game
// GAME_OVER | board frozen until a valid click
module chimp_game_fsm
  import chimp_pkg::*;
#(
  parameter int START_COUNT = 4,
  parameter int MAX_COUNT   = 9,
  parameter int MAX_STRIKES = 3,
  parameter int RETRY_LIMIT = 16
) (
  input logic              clk,
  input logic              iReset,
  chimp_game_fsm_if.slave  bus
);

  localparam int RETRY_W = $clog2(RETRY_LIMIT);
  localparam int BOARD_W = CELL_W * NUM_CELLS;

  state_t               state_q, state_d;
  logic [BOARD_W-1:0]   board_q, board_d;
  logic [4:0]           score_q, score_d;
  logic [1:0]           strikes_q, strikes_d;
  logic                 game_over_q, game_over_d;
  logic [3:0]           count_q, count_d;
  logic [3:0]           expected_q, expected_d;
  logic [3:0]           place_idx_q, place_idx_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;

  logic [NUM_CELLS-1:0] active_vec;
  logic [3:0]           free_idx;
  logic                 any_free;
  logic [3:0]           cand;
  logic                 cand_ok;
  logic                 place_ok;
  logic [3:0]           place_cell;
  logic                 click_valid;
  logic [3:0]           click_cell;
  logic                 click_active;
  logic [NUM_MSB:0]     click_num;
  logic                 unused_rand;

  assign unused_rand = ^bus.iRandNum[7:4];

  chimp_free_cell_finder u_finder (
    .active_i   (active_vec),
    .free_idx_o (free_idx),
    .any_free_o (any_free)
  );

  // Decode the board, the placement candidate and the clicked cell.
  always_comb begin
    for (int i = 0; i < NUM_CELLS; i++) begin
      active_vec[i] = board_q[i*CELL_W + ACTIVE_BIT];
    end
    cand         = bus.iRandNum[3:0];
    cand_ok      = (cand <= 4'd8) && !active_vec[cand];
    place_ok     = 1'b0;
    place_cell   = cand;
    if (cand_ok) begin
      place_ok = 1'b1;
    end else if (retry_q == RETRY_W'(RETRY_LIMIT - 1) && any_free) begin
      place_ok   = 1'b1;
      place_cell = free_idx;
    end
    click_valid  = bus.iClick && (bus.iBoxX <= 3'd2) && (bus.iBoxY <= 3'd2);
    click_cell   = ({2'b00, bus.iBoxY[1:0]} * 4'd3) + {2'b00, bus.iBoxX[1:0]};
    click_active = active_vec[click_cell];
    click_num    = board_q[cell_lsb(click_cell) +: NUM_MSB+1];
  end

  // Next-state, board, score and strike updates.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    score_d     = score_q;
    strikes_d   = strikes_q;
    count_d     = count_q;
    expected_d  = expected_q;
    place_idx_d = place_idx_q;
    retry_d     = retry_q;
    if (bus.iKey0 || bus.iGameMode != 2'b10) begin
      state_d = IDLE;
      board_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          score_d   = '0;
          strikes_d = '0;
          count_d   = 4'(START_COUNT);
          state_d   = CLEAR;
        end
        CLEAR: begin
          board_d     = '0;
          place_idx_d = 4'd1;
          retry_d     = '0;
          expected_d  = 4'd1;
          state_d     = PLACE;
        end
        PLACE: begin
          if (place_ok) begin
            board_d[cell_lsb(place_cell) +: CELL_W] = {1'b1, 1'b1, 1'b0, place_idx_q};
            place_idx_d = place_idx_q + 4'd1;
            retry_d     = '0;
            if (place_idx_q == count_q) state_d = SHOW;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end
        SHOW, PLAY: begin
          if (click_valid) begin
            // The first click of a round also hides every number.
            if (state_q == SHOW) begin
              for (int i = 0; i < NUM_CELLS; i++) board_d[i*CELL_W + SHOW_BIT] = 1'b0;
            end
            state_d = PLAY;
            if (click_active) begin
              if (click_num == {1'b0, expected_q}) begin
                board_d[cell_lsb(click_cell) +: CELL_W] = '0;
                expected_d = expected_q + 4'd1;
                if (click_num == {1'b0, count_q}) state_d = ROUND_WIN;
              end else begin
                state_d = STRIKE;
              end
            end
          end
        end
        ROUND_WIN: begin
          score_d = (score_q == '1) ? score_q : score_q + 5'd1;
          count_d = (count_q >= 4'(MAX_COUNT)) ? 4'(MAX_COUNT) : count_q + 4'd1;
          state_d = CLEAR;
        end
        STRIKE: begin
          strikes_d = strikes_q + 2'd1;
          state_d   = (strikes_q == 2'(MAX_STRIKES - 1)) ? GAME_OVER : CLEAR;
        end
        GAME_OVER: begin
          if (click_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    game_over_d = (state_d == GAME_OVER);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (iReset) begin
      state_q     <= IDLE;
      board_q     <= '0;
      score_q     <= '0;
      strikes_q   <= '0;
      game_over_q <= 1'b0;
      count_q     <= 4'(START_COUNT);
      expected_q  <= 4'd1;
      place_idx_q <= 4'd1;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      score_q     <= score_d;
      strikes_q   <= strikes_d;
      game_over_q <= game_over_d;
      count_q     <= count_d;
      expected_q  <= expected_d;
      place_idx_q <= place_idx_d;
      retry_q     <= retry_d;
    end
  end

  assign bus.oBoard    = board_q;
  assign bus.oScore    = score_q;
  assign bus.oStrikes  = strikes_q;
  assign bus.oGameOver = game_over_q;
  assign bus.oState    = state_q;

endmodule

// File: tb/tb_chimp_game_fsm.sv
// Randomized and directed bench for chimp_game_fsm against a cell-array game model.
module tb_chimp_game_fsm;

  localparam int S_IDLE = 0, S_CLEAR = 1, S_PLACE = 2, S_SHOW = 3;
  localparam int S_PLAY = 4, S_WIN = 5, S_STRIKE = 6, S_OVER = 7;
  localparam int RETRY_LIMIT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chimp_game_fsm_if bus ();
  chimp_game_fsm dut (.clk(clk), .iReset(rst), .bus(bus));

  // Game model: one entry per cell plus round bookkeeping.
  int m_phase, m_score, m_strikes, m_count, m_expect, m_place, m_retry;
  int m_num [9];
  bit m_act [9];
  bit m_shw [9];
  int checks = 0, passes = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [62:0] model_board();
    logic [62:0] b = '0;
    for (int i = 0; i < 9; i++) b[7*i +: 7] = {m_act[i], m_shw[i], 5'(m_num[i])};
    return b;
  endfunction

  task automatic clear_board();
    for (int i = 0; i < 9; i++) begin m_act[i] = 0; m_shw[i] = 0; m_num[i] = 0; end
  endtask

  task automatic put(input int c);
    m_act[c] = 1; m_shw[c] = 1; m_num[c] = m_place;
    if (m_place == m_count) m_phase = S_SHOW;
    m_place++;
    m_retry = 0;
  endtask

  task automatic model_update(input bit r, input bit key, input logic [1:0] mode,
                              input int rnd, input bit ck, input int bx, input int by);
    bit valid = ck && bx <= 2 && by <= 2;
    int k = 3*by + bx;
    int c = rnd % 16;
    int f;
    if (r) begin
      clear_board(); m_phase = S_IDLE; m_score = 0; m_strikes = 0;
      m_count = 4; m_expect = 1; m_place = 1; m_retry = 0;
    end else if (key || mode != 2'b10) begin
      clear_board(); m_phase = S_IDLE;
    end else begin
      case (m_phase)
        S_IDLE:  begin m_score = 0; m_strikes = 0; m_count = 4; m_phase = S_CLEAR; end
        S_CLEAR: begin clear_board(); m_place = 1; m_retry = 0; m_expect = 1; m_phase = S_PLACE; end
        S_PLACE: begin
          if (c < 9 && !m_act[c]) put(c);
          else if (m_retry == RETRY_LIMIT - 1) begin
            f = 0;
            while (m_act[f]) f++;
            put(f);
          end else m_retry++;
        end
        S_SHOW, S_PLAY: if (valid) begin
          if (m_phase == S_SHOW) for (int i = 0; i < 9; i++) m_shw[i] = 0;
          m_phase = S_PLAY;
          if (m_act[k]) begin
            if (m_num[k] == m_expect) begin
              if (m_num[k] == m_count) m_phase = S_WIN;
              m_act[k] = 0; m_shw[k] = 0; m_num[k] = 0;
              m_expect++;
            end else m_phase = S_STRIKE;
          end
        end
        S_WIN: begin
          m_score = (m_score < 31) ? m_score + 1 : 31;
          m_count = (m_count < 9) ? m_count + 1 : 9;
          m_phase = S_CLEAR;
        end
        S_STRIKE: begin
          m_strikes++;
          m_phase = (m_strikes == 3) ? S_OVER : S_CLEAR;
        end
        S_OVER: if (valid) m_phase = S_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit r, input bit key, input logic [1:0] mode, input int rnd,
                      input bit ck, input int bx, input int by);
    rst = r;
    bus.iKey0 = key; bus.iGameMode = mode; bus.iRandNum = 8'(rnd);
    bus.iClick = ck; bus.iBoxX = 3'(bx); bus.iBoxY = 3'(by);
    model_update(r, key, mode, rnd & 8'hff, ck, bx, by);
    @(posedge clk);
    #1;
    check("state", 64'(bus.oState), 64'(m_phase));
    check("board", 64'(bus.oBoard), 64'(model_board()));
    check("score", 64'(bus.oScore), 64'(m_score));
    check("strikes", 64'(bus.oStrikes), 64'(m_strikes));
    check("gameover", 64'(bus.oGameOver), 64'(m_phase == S_OVER));
  endtask

  task automatic idle_step();
    step(0, 0, 2'b10, $urandom, 0, 0, 0);
  endtask

  task automatic click(input int x, input int y);
    step(0, 0, 2'b10, $urandom, 1, x, y);
  endtask

  task automatic click_num(input int n);
    int k = 0;
    for (int i = 0; i < 9; i++) if (m_act[i] && m_num[i] == n) k = i;
    click(k % 3, k / 3);
  endtask

  task automatic click_empty();
    int k = 0;
    for (int i = 8; i >= 0; i--) if (!m_act[i]) k = i;
    click(k % 3, k / 3);
  endtask

  // Clicks in CLEAR/PLACE are sprinkled in; they must be ignored.
  task automatic run_to(input int target, input int budget);
    int n = 0;
    while (m_phase != target && n < budget) begin
      step(0, 0, 2'b10, $urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 3));
      n++;
    end
    check("run_to_budget", 64'(m_phase == target), 64'd1);
  endtask

  task automatic win_round();
    int cnt = m_count;
    run_to(S_SHOW, 200);
    for (int n = 1; n <= cnt; n++) begin
      if ($urandom_range(0, 3) == 0) click(3, $urandom_range(0, 2));
      if (n > 1 && $urandom_range(0, 3) == 0) click_empty();
      click_num(n);
    end
    check("round_won", 64'(bus.oState), 64'(S_WIN));
    idle_step();
  endtask

  function automatic int active_count();
    int n = 0;
    for (int i = 0; i < 9; i++) n += int'(bus.oBoard[7*i + 6]);
    return n;
  endfunction

  initial begin
    int place_cycles;
    int k;
    rst = 1'b1;
    bus.iKey0 = 0; bus.iGameMode = 0; bus.iRandNum = 0; bus.iClick = 0; bus.iBoxX = 0; bus.iBoxY = 0;

    for (int i = 0; i < 4; i++)
      step(1, $urandom_range(0, 1), 2'($urandom), $urandom, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7));

    // Fixed PRNG value: one direct hit, then fallback placement.
    place_cycles = 0;
    for (int i = 0; i < 200 && m_phase != S_SHOW; i++) begin
      step(0, 0, 2'b10, 0, 0, 0, 0);
      if (bus.oState == 3'd2) place_cycles++;
    end
    check("place_cycles", 64'(place_cycles), 64'd49);
    check("cell0_shown", 64'(bus.oBoard[6:0]), 64'b1100001);
    check("cell3_shown", 64'(bus.oBoard[27:21]), 64'b1100100);

    click(0, 0);
    check("cell0_cleared", 64'(bus.oBoard[6:0]), 64'd0);
    check("cell1_hidden", 64'(bus.oBoard[13:7]), 64'b1000010);
    click(1, 0); click(2, 0); click(0, 1);
    check("win_state", 64'(bus.oState), 64'(S_WIN));
    idle_step();
    check("score_one", 64'(bus.oScore), 64'd1);
    run_to(S_SHOW, 200);
    check("round2_count", 64'(active_count()), 64'd5);

    // Ignored clicks in PLAY, then three strikes.
    click_num(1);
    click_empty();
    click(3, 0);
    click(0, 3);
    click_num(3);
    check("strike_state", 64'(bus.oState), 64'(S_STRIKE));
    idle_step();
    check("strikes_one", 64'(bus.oStrikes), 64'd1);
    for (int s = 0; s < 2; s++) begin
      run_to(S_SHOW, 200);
      check("replay_count", 64'(active_count()), 64'd5);
      click_num(1);
      click_num(3);
      idle_step();
    end
    check("game_over", 64'(bus.oGameOver), 64'd1);
    check("over_state", 64'(bus.oState), 64'(S_OVER));
    click(3, 1);
    idle_step();
    click(1, 1);
    check("over_to_idle", 64'(bus.oState), 64'(S_IDLE));
    idle_step();

    // Long winning run: count caps at 9, score caps at 31.
    for (int r = 0; r < 33; r++) win_round();
    check("score_sat", 64'(bus.oScore), 64'd31);

    // Menu key beats a correct click mid-PLAY.
    run_to(S_SHOW, 200);
    click_num(1);
    k = 0;
    for (int i = 0; i < 9; i++) if (m_act[i] && m_num[i] == 2) k = i;
    step(0, 1, 2'b10, $urandom, 1, k % 3, k / 3);
    check("key_idle", 64'(bus.oState), 64'(S_IDLE));
    check("key_board", 64'(bus.oBoard), 64'd0);
    check("key_score_held", 64'(bus.oScore), 64'd31);

    // Mode exit during placement.
    idle_step();
    idle_step();
    for (int i = 0; i < 5; i++) idle_step();
    step(0, 0, 2'b01, $urandom, 0, 0, 0);
    check("mode_exit", 64'(bus.oState), 64'(S_IDLE));
    step(0, 0, 2'b00, $urandom, 1, 0, 0);

    // Free-running random play.
    for (int i = 0; i < 3000; i++) begin
      int x = $urandom_range(0, 3);
      int y = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) begin
        for (int j = 0; j < 9; j++) if (m_act[j] && m_num[j] == m_expect) begin x = j % 3; y = j / 3; end
      end
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) == 0) ? 2'($urandom) : 2'b10,
           $urandom, ($urandom_range(0, 2) == 0), x, y);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
